// File: rtl/hdmi_video_timing.sv
// hdmi_video_timing: PLL-lock-qualified raster timing generator (hsync/vsync/de, coordinates, strobes).
// Define VT_TEST_PATTERN_EN to add the registered eight-bar colour pattern output tp_rgb.
module hdmi_video_timing #(
  parameter int H_ACTIVE    = 800,
  parameter int H_FRONT     = 40,
  parameter int H_SYNC      = 128,
  parameter int H_BACK      = 88,
  parameter int V_ACTIVE    = 600,
  parameter int V_FRONT     = 1,
  parameter int V_SYNC      = 4,
  parameter int V_BACK      = 23,
  parameter int HS_POL      = 1,
  parameter int VS_POL      = 1,
  parameter int LOCK_CYCLES = 1024,
  parameter int CW          = 12
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          pll_locked,
  output logic          hsync,
  output logic          vsync,
  output logic          de,
  output logic [CW-1:0] x,
  output logic [CW-1:0] y,
  output logic          line_start,
  output logic          frame_start,
  output logic          running
`ifdef VT_TEST_PATTERN_EN
  ,output logic [23:0]  tp_rgb
`endif
);
  localparam int LW = $clog2(LOCK_CYCLES + 1);
  localparam logic [LW-1:0] LC_MAX = LW'(LOCK_CYCLES - 1);
  localparam logic [CW-1:0] HA  = CW'(H_ACTIVE);
  localparam logic [CW-1:0] HS0 = CW'(H_ACTIVE + H_FRONT);
  localparam logic [CW-1:0] HS1 = CW'(H_ACTIVE + H_FRONT + H_SYNC);
  localparam logic [CW-1:0] HL  = CW'(H_ACTIVE + H_FRONT + H_SYNC + H_BACK - 1);
  localparam logic [CW-1:0] VA  = CW'(V_ACTIVE);
  localparam logic [CW-1:0] VS0 = CW'(V_ACTIVE + V_FRONT);
  localparam logic [CW-1:0] VS1 = CW'(V_ACTIVE + V_FRONT + V_SYNC);
  localparam logic [CW-1:0] VL  = CW'(V_ACTIVE + V_FRONT + V_SYNC + V_BACK - 1);
  localparam logic HP = (HS_POL != 0);
  localparam logic VP = (VS_POL != 0);

  typedef enum logic {WAIT_LOCK, RUN} state_t;

  state_t        state_q, state_d;
  logic          lock_s1_q, lock_s2_q;
  logic [LW-1:0] lcnt_q, lcnt_d;
  logic [CW-1:0] hc_q, hc_d, vc_q, vc_d;
  logic          run, h_end, act, hs_d, vs_d;

  assign run     = state_q == RUN;
  assign running = run;
  assign h_end   = hc_q == HL;
  assign act     = run && hc_q < HA && vc_q < VA;
  assign hs_d    = run && hc_q >= HS0 && hc_q < HS1 ? HP : ~HP;
  assign vs_d    = run && vc_q >= VS0 && vc_q < VS1 ? VP : ~VP;

  // Counters only advance in RUN; any exit (lock loss) parks them at the origin.
  always_comb begin
    state_d = state_q;
    lcnt_d  = '0;
    hc_d    = '0;
    vc_d    = '0;
    if (!run) begin
      state_d = lock_s2_q && lcnt_q == LC_MAX ? RUN : WAIT_LOCK;
      lcnt_d  = lock_s2_q && lcnt_q != LC_MAX ? lcnt_q + 1'b1 : '0;
    end else if (!lock_s2_q) begin
      state_d = WAIT_LOCK;
    end else begin
      hc_d = h_end ? '0 : hc_q + 1'b1;
      vc_d = !h_end ? vc_q : vc_q == VL ? '0 : vc_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lock_s1_q   <= 1'b0;
      lock_s2_q   <= 1'b0;
      state_q     <= WAIT_LOCK;
      lcnt_q      <= '0;
      hc_q        <= '0;
      vc_q        <= '0;
      hsync       <= ~HP;
      vsync       <= ~VP;
      de          <= 1'b0;
      x           <= '0;
      y           <= '0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      lock_s1_q   <= pll_locked;
      lock_s2_q   <= lock_s1_q;
      state_q     <= state_d;
      lcnt_q      <= lcnt_d;
      hc_q        <= hc_d;
      vc_q        <= vc_d;
      hsync       <= hs_d;
      vsync       <= vs_d;
      de          <= act;
      x           <= act ? hc_q : '0;
      y           <= act ? vc_q : '0;
      line_start  <= run && hc_q == '0 && vc_q < VA;
      frame_start <= run && hc_q == '0 && vc_q == '0;
    end
  end

`ifdef VT_TEST_PATTERN_EN
  localparam int BW  = H_ACTIVE / 8;
  localparam int BWD = BW == 0 ? 1 : BW;
  logic [2:0]  bar;
  logic [23:0] rgb_d;
  // Bar index 7 is black, which also covers the remainder pixels past 8*BW.
  assign bar   = hc_q >= CW'(8 * BW) ? 3'd7 : 3'(hc_q / CW'(BWD));
  assign rgb_d = act ? {{8{~bar[1]}}, {8{~bar[2]}}, {8{~bar[0]}}} : 24'h0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) tp_rgb <= 24'h0;
    else tp_rgb <= rgb_d;
  end
`endif
endmodule

// File: tb/tb_hdmi_video_timing.sv
// tb_hdmi_video_timing: two small-raster instances (positive and negative sync polarity) checked
// every cycle against a frame-position reference model, plus directed lock/reset scenarios.
module tb_hdmi_video_timing;
  localparam int LC = 16;

  typedef struct packed {
    logic        hs;
    logic        vs;
    logic        de;
    logic [11:0] x;
    logic [11:0] y;
    logic        ls;
    logic        fs;
    logic [23:0] rgb;
  } vo_t;

  logic clk = 1'b0, rst_n = 1'b0, pll_locked = 1'b0;
  always #5 clk = ~clk;

  logic a_hs, a_vs, a_de, a_ls, a_fs, a_run;
  logic b_hs, b_vs, b_de, b_ls, b_fs, b_run;
  logic [11:0] a_x, a_y, b_x, b_y;
  logic [23:0] a_rgb, b_rgb;

  hdmi_video_timing #(.H_ACTIVE(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(3),
    .V_ACTIVE(4), .V_FRONT(1), .V_SYNC(2), .V_BACK(1), .HS_POL(1), .VS_POL(1),
    .LOCK_CYCLES(LC), .CW(12)) dut_a (
    .clk(clk), .rst_n(rst_n), .pll_locked(pll_locked), .hsync(a_hs), .vsync(a_vs),
    .de(a_de), .x(a_x), .y(a_y), .line_start(a_ls), .frame_start(a_fs), .running(a_run)
`ifdef VT_TEST_PATTERN_EN
    , .tp_rgb(a_rgb)
`endif
  );

  hdmi_video_timing #(.H_ACTIVE(16), .H_FRONT(2), .H_SYNC(3), .H_BACK(3),
    .V_ACTIVE(4), .V_FRONT(1), .V_SYNC(2), .V_BACK(1), .HS_POL(0), .VS_POL(0),
    .LOCK_CYCLES(LC), .CW(12)) dut_b (
    .clk(clk), .rst_n(rst_n), .pll_locked(pll_locked), .hsync(b_hs), .vsync(b_vs),
    .de(b_de), .x(b_x), .y(b_y), .line_start(b_ls), .frame_start(b_fs), .running(b_run)
`ifdef VT_TEST_PATTERN_EN
    , .tp_rgb(b_rgb)
`endif
  );

`ifndef VT_TEST_PATTERN_EN
  assign a_rgb = 24'h0;
  assign b_rgb = 24'h0;
`endif

  int cmp = 0, mis = 0;

  // Reference: lock-history, qualification count, and raster position t counted since entry to RUN.
  bit s1, s2, run, prun;
  int lc, t, pt;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1 = 0; s2 = 0; run = 0; prun = 0; lc = 0; t = 0; pt = 0;
    end else begin
      prun = run;
      pt = t;
      if (run) begin
        if (!s2) begin run = 0; lc = 0; t = 0; end
        else t++;
      end else if (!s2) lc = 0;
      else if (lc == LC - 1) begin run = 1; t = 0; lc = 0; end
      else lc++;
      s2 = s1;
      s1 = pll_locked;
    end
  end

  function automatic vo_t ref_out(int ha, int hf, int hsn, int hb, int va, int vf, int vsn, int vb,
                                  bit hp, bit vp, bit r, int tt);
    vo_t o;
    int ht, vt, p, hc, vc;
    logic [23:0] bars [8] = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                              24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};
    ht = ha + hf + hsn + hb;
    vt = va + vf + vsn + vb;
    o = '0;
    o.hs = !hp;
    o.vs = !vp;
    if (r) begin
      p = tt % (ht * vt);
      hc = p % ht;
      vc = p / ht;
      if (hc >= ha + hf && hc < ha + hf + hsn) o.hs = hp;
      if (vc >= va + vf && vc < va + vf + vsn) o.vs = vp;
      o.de = hc < ha && vc < va;
      if (o.de) begin
        o.x = 12'(hc);
        o.y = 12'(vc);
`ifdef VT_TEST_PATTERN_EN
        o.rgb = hc < 8 * (ha / 8) ? bars[hc / (ha / 8)] : 24'h0;
`endif
      end
      o.ls = hc == 0 && vc < va;
      o.fs = hc == 0 && vc == 0;
    end
    return o;
  endfunction

  function automatic vo_t exp_a(); return ref_out(8, 2, 3, 3, 4, 1, 2, 1, 1, 1, prun, pt); endfunction
  function automatic vo_t exp_b(); return ref_out(16, 2, 3, 3, 4, 1, 2, 1, 0, 0, prun, pt); endfunction
  function automatic vo_t obs_a(); return {a_hs, a_vs, a_de, a_x, a_y, a_ls, a_fs, a_rgb}; endfunction
  function automatic vo_t obs_b(); return {b_hs, b_vs, b_de, b_x, b_y, b_ls, b_fs, b_rgb}; endfunction

  task automatic test_reset();
    rst_n = 0;
    pll_locked = 1;
    repeat (4) begin
      @(posedge clk); #2;
      cmp++; if (obs_a() !== exp_a()) begin mis++; $display("FAIL reset_a got=%h exp=%h", obs_a(), exp_a()); end
      cmp++; if (obs_b() !== exp_b()) begin mis++; $display("FAIL reset_b got=%h exp=%h", obs_b(), exp_b()); end
    end
    cmp++;
    if ({a_hs, a_vs, a_de, a_run, b_hs, b_vs, b_de, b_run} !== 8'b0000_1100) begin
      mis++;
      $display("FAIL reset_levels got=%b exp=00001100", {a_hs, a_vs, a_de, a_run, b_hs, b_vs, b_de, b_run});
    end
  endtask

  task automatic test_lock_qual();
    int rise = 0;
    rst_n = 1;
    for (int k = 1; k <= 60 && rise == 0; k++) begin
      @(posedge clk); #2;
      cmp++; if (obs_a() !== exp_a()) begin mis++; $display("FAIL qual_a k=%0d got=%h exp=%h", k, obs_a(), exp_a()); end
      cmp++; if (obs_b() !== exp_b()) begin mis++; $display("FAIL qual_b k=%0d got=%h exp=%h", k, obs_b(), exp_b()); end
      if (a_run) rise = k;
    end
    cmp++; if (rise != 18) begin mis++; $display("FAIL qual_rise got=%0d exp=18", rise); end
    @(posedge clk); #2;
    cmp++;
    if ({a_fs, a_de, a_x, a_y} !== {2'b11, 24'h0}) begin
      mis++;
      $display("FAIL qual_first fs=%b de=%b x=%0d y=%0d exp fs=1 de=1 x=0 y=0", a_fs, a_de, a_x, a_y);
    end
  endtask

  task automatic test_lock_glitch();
    int rise = 0;
    rst_n = 0;
    @(posedge clk); #2;
    rst_n = 1;
    for (int k = 1; k <= 80 && rise == 0; k++) begin
      @(posedge clk); #2;
      cmp++; if (obs_a() !== exp_a()) begin mis++; $display("FAIL glitch_a k=%0d got=%h exp=%h", k, obs_a(), exp_a()); end
      cmp++; if (a_run !== run || b_run !== run) begin mis++; $display("FAIL glitch_run k=%0d got=%b%b exp=%b", k, a_run, b_run, run); end
      if (a_run) rise = k;
      pll_locked = k != 12;
    end
    cmp++; if (rise != 31) begin mis++; $display("FAIL glitch_rise got=%0d exp=31", rise); end
  endtask

  task automatic test_raster();
    int n_de = 0, n_hs = 0, n_vs = 0, n_ls = 0, n_fs = 0, k = 0;
    while (!a_fs && k < 200) begin @(posedge clk); #2; k++; end
    cmp++; if (!a_fs) begin mis++; $display("FAIL raster_fs_timeout got=0 exp=1"); end
    for (int c = 0; c < 256; c++) begin
      cmp++; if (obs_a() !== exp_a()) begin mis++; $display("FAIL raster_a c=%0d got=%h exp=%h", c, obs_a(), exp_a()); end
      cmp++; if (obs_b() !== exp_b()) begin mis++; $display("FAIL raster_b c=%0d got=%h exp=%h", c, obs_b(), exp_b()); end
      if (c < 128) begin n_de += a_de; n_hs += a_hs; n_vs += a_vs; n_ls += a_ls; n_fs += a_fs; end
      @(posedge clk); #2;
    end
    cmp++;
    if ({n_de, n_hs, n_vs, n_ls, n_fs} !== {32'd32, 32'd24, 32'd32, 32'd4, 32'd1}) begin
      mis++;
      $display("FAIL raster_counts de=%0d hs=%0d vs=%0d ls=%0d fs=%0d exp 32 24 32 4 1", n_de, n_hs, n_vs, n_ls, n_fs);
    end
  endtask

  task automatic test_lock_loss();
    int k = 0;
    while (!(a_de && a_x == 3 && a_y == 2) && k < 300) begin @(posedge clk); #2; k++; end
    cmp++; if (!(a_de && a_x == 3 && a_y == 2)) begin mis++; $display("FAIL loss_find got x=%0d y=%0d exp x=3 y=2", a_x, a_y); end
    pll_locked = 0;
    for (int c = 1; c <= 6; c++) begin
      @(posedge clk); #2;
      cmp++; if (obs_a() !== exp_a()) begin mis++; $display("FAIL loss_a c=%0d got=%h exp=%h", c, obs_a(), exp_a()); end
      cmp++; if (obs_b() !== exp_b()) begin mis++; $display("FAIL loss_b c=%0d got=%h exp=%h", c, obs_b(), exp_b()); end
      if (c == 4) begin
        cmp++;
        if ({a_de, a_hs, a_vs, b_de, b_hs, b_vs, a_run} !== 7'b000_0110) begin
          mis++;
          $display("FAIL loss_idle got=%b exp=0000110", {a_de, a_hs, a_vs, b_de, b_hs, b_vs, a_run});
        end
      end
    end
    pll_locked = 1;
    k = 0;
    while (!a_run && k < 60) begin
      @(posedge clk); #2; k++;
      cmp++; if (obs_a() !== exp_a()) begin mis++; $display("FAIL requal_a got=%h exp=%h", obs_a(), exp_a()); end
    end
    @(posedge clk); #2;
    cmp++;
    if ({a_fs, a_de, a_x, a_y, b_fs} !== {2'b11, 24'h0, 1'b1}) begin
      mis++;
      $display("FAIL reentry fs=%b de=%b x=%0d y=%0d bfs=%b exp 1 1 0 0 1", a_fs, a_de, a_x, a_y, b_fs);
    end
  endtask

  task automatic test_random_lock();
    int low = 0;
    for (int c = 0; c < 900; c++) begin
      @(posedge clk); #2;
      cmp++; if (obs_a() !== exp_a()) begin mis++; $display("FAIL rand_a c=%0d got=%h exp=%h", c, obs_a(), exp_a()); end
      cmp++; if (obs_b() !== exp_b()) begin mis++; $display("FAIL rand_b c=%0d got=%h exp=%h", c, obs_b(), exp_b()); end
      cmp++; if (a_run !== run || b_run !== run) begin mis++; $display("FAIL rand_run c=%0d got=%b%b exp=%b", c, a_run, b_run, run); end
      if (low > 0) low--;
      else if ($urandom_range(0, 199) == 0) low = $urandom_range(1, 4);
      pll_locked = low == 0;
    end
  endtask

  task automatic test_async_reset();
    int k = 0, rise = 0;
    pll_locked = 1;
    while (!(a_de && a_y == 1) && k < 400) begin @(posedge clk); #2; k++; end
    cmp++; if (!(a_de && a_y == 1)) begin mis++; $display("FAIL areset_find got y=%0d de=%b exp y=1 de=1", a_y, a_de); end
    rst_n = 0;
    #1;
    cmp++;
    if ({a_de, a_hs, a_vs, a_ls, a_fs, a_run, b_hs, b_vs, a_x, a_y} !== {8'b0000_0011, 24'h0}) begin
      mis++;
      $display("FAIL areset_idle got=%b x=%0d y=%0d exp=00000011 x=0 y=0",
               {a_de, a_hs, a_vs, a_ls, a_fs, a_run, b_hs, b_vs}, a_x, a_y);
    end
    @(posedge clk); #2;
    rst_n = 1;
    for (int j = 1; j <= 60 && rise == 0; j++) begin
      @(posedge clk); #2;
      cmp++; if (obs_a() !== exp_a()) begin mis++; $display("FAIL areset_a j=%0d got=%h exp=%h", j, obs_a(), exp_a()); end
      if (a_run) rise = j;
    end
    cmp++; if (rise != 18) begin mis++; $display("FAIL areset_rise got=%0d exp=18", rise); end
  endtask

  initial begin
    test_reset();
    test_lock_qual();
    test_lock_glitch();
    test_raster();
    test_lock_loss();
    test_random_lock();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, mis);
    $finish;
  end
endmodule
